// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM in, registered MEM/WB out, one bus access in flight.
// Ports: EX/MEM inputs, req/ack data bus, MEM/WB outputs, fault pulses.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_width,
  input  logic        in_mem_unsigned,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        mem_misalign,
  output logic        mem_bus_error,
  output logic [31:0] mem_fault_addr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [1:0]      off;
  logic            is_mem, is_byte, is_half, is_word;
  logic            misal, timeout;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d, shifted, load_val;

  always_comb begin
    off     = in_alu_result[1:0];
    is_mem  = in_valid & (in_mem_read | in_mem_write);
    is_word = in_mem_width[1];
    is_half = (in_mem_width == 2'b01);
    is_byte = (in_mem_width == 2'b00);
    misal   = (is_half & off[0]) | (is_word & (off != 2'b00));
    be_d    = 4'b1111;
    wdata_d = in_rs2_data;
    unique case (1'b1)
      is_byte: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{in_rs2_data[7:0]}};
      end
      is_half: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{in_rs2_data[15:0]}};
      end
      default: ;
    endcase
    shifted  = bus_rdata >> {off, 3'b000};
    load_val = bus_rdata;
    unique case (1'b1)
      is_byte:
        load_val = {{24{~in_mem_unsigned & shifted[7]}},
                    shifted[7:0]};
      is_half:
        load_val = {{16{~in_mem_unsigned & shifted[15]}},
                    shifted[15:0]};
      default: ;
    endcase
    // An ack in the final counted cycle still wins over the timeout.
    timeout = (state == S_WAIT) & ~bus_ack
            & (cnt == CW'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d   = state;
    mem_stall = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_mem & ~misal) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_stall = ~bus_ack;
        if (bus_ack | timeout)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_be         <= '0;
      wb_valid       <= 1'b0;
      wb_pc          <= '0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      mem_misalign   <= 1'b0;
      mem_bus_error  <= 1'b0;
      mem_fault_addr <= '0;
    end else begin
      mem_misalign  <= 1'b0;
      mem_bus_error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wb_pc   <= in_pc;
          wb_rd   <= in_rd;
          wb_data <= in_alu_result;
          if (!in_valid) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else if (!is_mem) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
          end else if (misal) begin
            wb_valid       <= 1'b1;
            wb_reg_write   <= 1'b0;
            mem_misalign   <= 1'b1;
            mem_fault_addr <= in_alu_result;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            bus_req      <= 1'b1;
            bus_we       <= in_mem_write;
            bus_addr     <= {in_alu_result[31:2], 2'b00};
            bus_be       <= be_d;
            bus_wdata    <= wdata_d;
            cnt          <= '0;
          end
        end
        S_WAIT: begin
          wb_pc <= in_pc;
          wb_rd <= in_rd;
          if (bus_ack) begin
            bus_req      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= in_mem_read & in_reg_write;
            wb_data      <= in_mem_read ? load_val : 32'd0;
          end else if (timeout) begin
            bus_req        <= 1'b0;
            wb_valid       <= 1'b1;
            wb_reg_write   <= 1'b0;
            wb_data        <= 32'd0;
            mem_bus_error  <= 1'b1;
            mem_fault_addr <= in_alu_result;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, scoreboard queue of
// expected MEM/WB records, plus reset and back-to-back sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_alu_result, in_rs2_data;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic [1:0]  in_mem_width;
  logic        in_mem_unsigned;
  logic        mem_stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        mem_misalign, mem_bus_error;
  logic [31:0] mem_fault_addr;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_alu_result(in_alu_result),
    .in_rs2_data(in_rs2_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write),
    .in_mem_width(in_mem_width),
    .in_mem_unsigned(in_mem_unsigned),
    .mem_stall(mem_stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .mem_misalign(mem_misalign),
    .mem_bus_error(mem_bus_error),
    .mem_fault_addr(mem_fault_addr)
  );

  typedef struct {
    string       name;
    logic        rd_en, wr_en;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] alu, rs2, rdata;
    logic [4:0]  rd;
    int          ack;
    logic        rwi;
    logic [3:0]  be;
    logic [31:0] wdata, wbd;
    logic        cd, erw, mis, berr;
    int          stalls, reqs;
  } vec_t;

  typedef struct {
    logic [31:0] data, pc, fault;
    logic [4:0]  rd;
    logic        rw, cd, mis, berr;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(
    input string n, input logic rde, input logic wre,
    input logic [1:0] w, input logic u,
    input logic [31:0] alu, input logic [31:0] rs2,
    input logic [31:0] rdata, input logic [4:0] rd,
    input int ack, input logic rwi, input logic [3:0] be,
    input logic [31:0] wdata, input logic [31:0] wbd,
    input logic cd, input logic erw, input logic mis,
    input logic berr, input int st, input int rq);
    vec_t v;
    v.name = n; v.rd_en = rde; v.wr_en = wre;
    v.width = w; v.uns = u; v.alu = alu; v.rs2 = rs2;
    v.rdata = rdata; v.rd = rd; v.ack = ack; v.rwi = rwi;
    v.be = be; v.wdata = wdata; v.wbd = wbd; v.cd = cd;
    v.erw = erw; v.mis = mis; v.berr = berr;
    v.stalls = st; v.reqs = rq;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_alu_result = 0;
    in_rs2_data = 0; in_rd = 0; in_reg_write = 0;
    in_mem_read = 0; in_mem_write = 0;
    in_mem_width = 0; in_mem_unsigned = 0;
    bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic check_wb(input string n);
    exp_t e;
    if (sb.size() == 0) begin
      chk({n, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({n, "_wb_valid"}, {31'd0, wb_valid}, 1);
    chk({n, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    chk({n, "_wb_pc"}, wb_pc, e.pc);
    chk({n, "_wb_rw"}, {31'd0, wb_reg_write}, {31'd0, e.rw});
    if (e.cd) chk({n, "_wb_data"}, wb_data, e.data);
    chk({n, "_misalign"}, {31'd0, mem_misalign},
        {31'd0, e.mis});
    chk({n, "_bus_err"}, {31'd0, mem_bus_error},
        {31'd0, e.berr});
    if (e.mis | e.berr)
      chk({n, "_fault"}, mem_fault_addr, e.fault);
  endtask

  // Called just after a rising edge; returns just after the
  // edge that retires the instruction.
  task automatic run_op(input vec_t v, input logic [31:0] pc);
    exp_t e;
    int stalls, reqs, w;
    bit seen, done;
    in_valid = 1; in_pc = pc; in_alu_result = v.alu;
    in_rs2_data = v.rs2; in_rd = v.rd;
    in_reg_write = v.rwi; in_mem_read = v.rd_en;
    in_mem_write = v.wr_en; in_mem_width = v.width;
    in_mem_unsigned = v.uns;
    e.data = v.wbd; e.pc = pc; e.fault = v.alu;
    e.rd = v.rd; e.rw = v.erw; e.cd = v.cd;
    e.mis = v.mis; e.berr = v.berr;
    sb.push_back(e);
    stalls = 0; reqs = 0; w = 0; seen = 0; done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus_req) begin
        if (!seen) begin
          seen = 1;
          chk({v.name, "_addr"}, bus_addr,
              {v.alu[31:2], 2'b00});
          chk({v.name, "_be"}, {28'd0, bus_be},
              {28'd0, v.be});
          chk({v.name, "_we"}, {31'd0, bus_we},
              {31'd0, v.wr_en});
          if (v.wr_en)
            chk({v.name, "_wdata"}, bus_wdata, v.wdata);
        end
        reqs++;
        if (v.ack >= 0 && w == v.ack) begin
          bus_ack = 1;
          bus_rdata = v.rdata;
        end
        w++;
      end
      #1;
      if (mem_stall) stalls++;
      @(posedge clk);
      #1;
      bus_ack = 0;
      if (wb_valid) done = 1;
    end
    if (!done) begin
      chk({v.name, "_retire_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      check_wb(v.name);
    end
    chk({v.name, "_stall_cycles"}, stalls, v.stalls);
    chk({v.name, "_req_cycles"}, reqs, v.reqs);
    idle_inputs();
  endtask

  initial begin
    exp_t e;
    vt[0]  = mk("lb_neg", 1, 0, 2'b00, 0, 32'h1003, 0,
                32'h80AA5511, 5'd1, 0, 1, 4'b1000, 0,
                32'hFFFFFF80, 1, 1, 0, 0, 1, 1);
    vt[1]  = mk("sh", 0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD,
                0, 5'd2, 3, 0, 4'b1100, 32'hABCDABCD,
                0, 0, 0, 0, 0, 4, 4);
    vt[2]  = mk("lw_mis", 1, 0, 2'b10, 0, 32'h3001, 0, 0,
                5'd3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[3]  = mk("lw_tmo", 1, 0, 2'b10, 0, 32'h4000, 0, 0,
                5'd4, -1, 1, 4'b1111, 0, 0, 0, 0, 0, 1, 6, 5);
    vt[4]  = mk("add", 0, 0, 2'b00, 0, 32'h55, 0, 0, 5'd5,
                0, 1, 0, 0, 32'h55, 1, 1, 0, 0, 0, 0);
    vt[5]  = mk("lh_neg", 1, 0, 2'b01, 0, 32'h12, 0,
                32'h8001FFFF, 5'd6, 0, 1, 4'b1100, 0,
                32'hFFFF8001, 1, 1, 0, 0, 1, 1);
    vt[6]  = mk("lbu", 1, 0, 2'b00, 1, 32'h1, 0,
                32'h80AA5511, 5'd7, 1, 1, 4'b0010, 0,
                32'h55, 1, 1, 0, 0, 2, 2);
    vt[7]  = mk("sb", 0, 1, 2'b00, 0, 32'h5, 32'hEE, 0,
                5'd8, 0, 0, 4'b0010, 32'hEEEEEEEE,
                0, 0, 0, 0, 0, 1, 1);
    vt[8]  = mk("sw", 0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 0,
                5'd9, 1, 0, 4'b1111, 32'hDEADBEEF,
                0, 0, 0, 0, 0, 2, 2);
    vt[9]  = mk("lw_w3", 1, 0, 2'b11, 1, 32'h20, 0,
                32'hCAFEF00D, 5'd10, 2, 1, 4'b1111, 0,
                32'hCAFEF00D, 1, 1, 0, 0, 3, 3);
    vt[10] = mk("sh_mis", 0, 1, 2'b01, 0, 32'h2003, 32'h1, 0,
                5'd11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[11] = mk("lw_ack_last", 1, 0, 2'b10, 0, 32'h44, 0,
                32'h13572468, 5'd12, 4, 1, 4'b1111, 0,
                32'h13572468, 1, 1, 0, 0, 5, 5);

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", {31'd0, mem_stall}, 0);
    rst = 0;

    for (int i = 0; i < 12; i++)
      run_op(vt[i], 32'h100 + 32'(i * 4));

    // Two ALU ops back to back retire on consecutive edges.
    in_valid = 1; in_pc = 32'h200; in_alu_result = 32'h11;
    in_rd = 5'd13; in_reg_write = 1;
    e.data = 32'h11; e.pc = 32'h200; e.fault = 0;
    e.rd = 5'd13; e.rw = 1; e.cd = 1; e.mis = 0; e.berr = 0;
    sb.push_back(e);
    #1;
    chk("b2b_stall", {31'd0, mem_stall}, 0);
    @(posedge clk); #1;
    check_wb("b2b_a");
    in_pc = 32'h204; in_alu_result = 32'h22; in_rd = 5'd14;
    e.data = 32'h22; e.pc = 32'h204; e.rd = 5'd14;
    sb.push_back(e);
    @(posedge clk); #1;
    check_wb("b2b_b");
    idle_inputs();
    @(posedge clk); #1;
    chk("bubble_wb_valid", {31'd0, wb_valid}, 0);
    chk("bubble_wb_rw", {31'd0, wb_reg_write}, 0);

    // Reset while WAIT, then a stray ack that must be ignored.
    in_valid = 1; in_pc = 32'h300; in_alu_result = 32'h40;
    in_rd = 5'd15; in_reg_write = 1; in_mem_read = 1;
    in_mem_width = 2'b10;
    @(posedge clk); #1;
    chk("rw_req_up", {31'd0, bus_req}, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rw_req_clr", {31'd0, bus_req}, 0);
    chk("rw_wb_valid", {31'd0, wb_valid}, 0);
    chk("rw_be_clr", {28'd0, bus_be}, 0);
    chk("rw_addr_clr", bus_addr, 0);
    rst = 0;
    idle_inputs();
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_ack = 0;
    chk("rw_ack_ign_valid", {31'd0, wb_valid}, 0);
    chk("rw_ack_ign_req", {31'd0, bus_req}, 0);
    run_op(mk("lhu_rst", 1, 0, 2'b01, 1, 32'h10, 0,
              32'h8001FFFF, 5'd16, 0, 1, 4'b0011, 0,
              32'h0000FFFF, 1, 1, 0, 0, 1, 1), 32'h304);

    @(posedge clk); #1;
    chk("pulse_clear", {30'd0, mem_misalign, mem_bus_error}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage that consumes the EX/MEM register contents and produces the registered MEM/WB result.
- Performs loads and stores over a single-outstanding req/ack data bus.
  - Stores: byte-lane steering.
  - Loads: lane extraction plus sign/zero extension.
- Raises `mem_stall` so EX/MEM holds while an access is in flight.
- Detects misaligned accesses and bus timeouts.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
TIMEOUT_CYCLES, 1023, WAIT cycles without bus_ack before the access is aborted as a bus error (min 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  EX/MEM holds a valid instruction
in_pc  input  32  instruction PC
in_alu_result  input  32  address for mem ops, else writeback value
in_rs2_data  input  32  store data (already forwarded)
in_rd  input  5  destination register
in_reg_write  input  1  instruction writes rd
in_mem_read  input  1  load
in_mem_write  input  1  store
in_mem_width  input  2  00 byte, 01 half, 10 word, 11 treated as word
in_mem_unsigned  input  1  zero-extend load (LBU/LHU)
mem_stall  output  1  hold EX/MEM and upstream this cycle
bus_req  output  1  access request, held until bus_ack
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address ({in_alu_result[31:2],2'b00})
bus_wdata  output  32  lane-replicated store data
bus_be  output  4  byte enables
bus_ack  input  1  access complete; bus_rdata valid same cycle
bus_rdata  input  32  read data word
wb_valid  output  1  MEM/WB valid
wb_pc  output  32  MEM/WB PC
wb_rd  output  5  MEM/WB destination
wb_reg_write  output  1  MEM/WB register write enable
wb_data  output  32  MEM/WB writeback data
mem_misalign  output  1  1-cycle pulse: misaligned access, no bus request issued
mem_bus_error  output  1  1-cycle pulse: bus timeout
mem_fault_addr  output  32  offending byte address, valid with either pulse

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE; timeout counter 0.
  - Every output register to 0.
  - Reset during WAIT abandons the access: bus_req is 0 after the edge, and a later bus_ack is ignored.
- FSM has two states, IDLE and WAIT.
- IDLE, with `is_mem = in_valid & (in_mem_read | in_mem_write)` and aligned:
  - mem_stall = 1, combinational, in this cycle.
  - At the edge: register bus_req=1, bus_we=in_mem_write, bus_addr, bus_be, bus_wdata; clear the counter; go to WAIT.
- WAIT:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata stay stable.
  - mem_stall = ~bus_ack.
  - On bus_ack, at the edge:
    - bus_req=0; go to IDLE.
    - Load: wb_valid=1, wb_data = extracted load value, wb_reg_write = in_reg_write.
    - Store: wb_valid=1, wb_reg_write=0.
  - With no ack, the counter increments each cycle. When it reaches TIMEOUT_CYCLES and bus_ack=0, at the edge:
    - bus_req=0; mem_bus_error=1 for 1 cycle; mem_fault_addr=in_alu_result.
    - wb_valid=1, wb_reg_write=0; go to IDLE.
  - bus_ack in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
- Minimum memory-op latency: 2 cycles (accept, ack).
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus request; mem_stall=0.
  - Next edge: mem_misalign=1 for 1 cycle, mem_fault_addr=addr, wb_valid=1, wb_reg_write=0.
- Non-memory instruction in IDLE:
  - mem_stall=0.
  - Next edge: wb_valid=1, wb_data=in_alu_result, wb_rd/wb_pc/wb_reg_write copied.
- in_valid=0 in IDLE: next edge wb_valid=0, wb_reg_write=0.
- Store lanes, with o = addr[1:0]:
  - Byte: be = 4'b0001<<o; wdata = {4{rs2[7:0]}}.
  - Half: be = 4'b0011<<o; wdata = {2{rs2[15:0]}}.
  - Word: be = 4'b1111; wdata = rs2.
- Load extraction:
  - Byte: rdata[8*o +: 8]; half: rdata[8*o +: 16]; word: rdata.
  - Sign-extend unless in_mem_unsigned; in_mem_unsigned is ignored for word.
- wb_rd and wb_pc are taken from the instruction being retired. The instruction stays on the inputs through WAIT because of mem_stall.
- bus_ack while in IDLE is ignored.
- Status pulses (mem_misalign, mem_bus_error) return to 0 the cycle after assertion unless re-triggered.

Test Plan:
- LB from 0x1003 (unsigned=0), rdata=0x80AA5511, ack in 1st WAIT cycle:
  - bus_be=0001<<3=1000, bus_addr=0x1000.
  - mem_stall high for 1 cycle.
  - wb_data=0xFFFFFF80, wb_reg_write=1.
- SH rs2=0x1234ABCD to 0x2002, ack after 3 WAIT cycles:
  - bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
  - mem_stall high for 4 cycles total.
  - wb_valid=1, wb_reg_write=0.
- LW from 0x3001:
  - No bus_req; mem_stall=0.
  - Next cycle: mem_misalign=1, mem_fault_addr=0x3001, wb_reg_write=0.
- TIMEOUT_CYCLES=4, LW from 0x4000, no ack:
  - bus_req high for exactly 5 cycles.
  - Then mem_bus_error pulse, mem_fault_addr=0x4000, return to IDLE.
- ADD result 0x55 → rd=5, no stall:
  - Next cycle: wb_valid=1, wb_rd=5, wb_data=0x55.
  - A back-to-back second ALU op retires the following cycle.
- rst asserted in WAIT, then bus_ack on the following cycle:
  - Outputs all 0 after the edge; the ack is ignored.
  - A new LHU from 0x10 with rdata=0x8001FFFF yields wb_data=0x0000FFFF.
